// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register (ctrl + data) with
// valid/ready handshake, flush-to-bubble and optional 2-entry skid buffer.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   upstream:   valid_i, ready_o, ctrl_i, data_i
//   control:    flush_i (drops held beats and the current input beat)
//   downstream: valid_o, ready_i, ctrl_o (zero when no beat), data_o
//   status:     occ_o (beats held, 0..2)
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic              accept;
  logic              emit;

  assign accept = valid_i & ready_o & ~flush_i;
  assign emit   = main_v & ready_i;

  generate
    if (SKID == 0) begin : g_single

      assign ready_o = ~main_v | ready_i;
      assign skid_v  = 1'b0;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          main_v    <= 1'b0;
          main_ctrl <= '0;
          main_data <= '0;
        end else if (flush_i) begin
          main_v <= 1'b0;
        end else if (accept) begin
          main_v    <= 1'b1;
          main_ctrl <= ctrl_i;
          main_data <= data_i;
        end else if (emit) begin
          main_v <= 1'b0;
        end
      end

    end else begin : g_skid

      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t            state_q;
      state_t            state_d;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      logic              ld_main_in;
      logic              ld_main_skid;
      logic              ld_skid;

      // ready_o comes straight from a flop: no path from ready_i.
      assign main_v  = (state_q != ST_EMPTY);
      assign skid_v  = (state_q == ST_FULL);
      assign ready_o = ~skid_v;

      always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush_i) begin
          state_d = ST_EMPTY;
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d    = ST_ONE;
                ld_main_in = 1'b1;
              end
            end
            ST_ONE: begin
              if (accept && emit) begin
                ld_main_in = 1'b1;
              end else if (accept) begin
                state_d = ST_FULL;
                ld_skid = 1'b1;
              end else if (emit) begin
                state_d = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (emit) begin
                state_d      = ST_ONE;
                ld_main_skid = 1'b1;
              end
            end
            default: begin
              state_d = ST_EMPTY;
            end
          endcase
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          state_q   <= ST_EMPTY;
          main_ctrl <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else begin
          state_q <= state_d;
          if (ld_main_in) begin
            main_ctrl <= ctrl_i;
            main_data <= data_i;
          end else if (ld_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
          if (ld_skid) begin
            skid_ctrl <= ctrl_i;
            skid_data <= data_i;
          end
        end
      end

    end
  endgenerate

  // Bubbles carry a zero control field so they can never trigger writes.
  assign valid_o = main_v;
  assign ctrl_o  = main_v ? main_ctrl : '0;
  assign data_o  = main_data;
  assign occ_o   = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + randomized bench for pipe_stage_reg,
// both SKID=1 (u1) and SKID=0 (u0) instances driven by shared inputs.
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 69;
  localparam int GW = 1 + 1 + 2 + CW + DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          valid_i;
  logic          flush_i;
  logic          ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          v1, r1, v0, r0;
  logic [CW-1:0] c1, c0;
  logic [DW-1:0] d1, d0;
  logic [1:0]    o1, o0;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
    .clk_i(clk), .rst_i(rst_n),
    .valid_i(valid_i), .ready_o(r1),
    .ctrl_i(ctrl_i), .data_i(data_i),
    .flush_i(flush_i),
    .valid_o(v1), .ready_i(ready_i),
    .ctrl_o(c1), .data_o(d1), .occ_o(o1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
    .clk_i(clk), .rst_i(rst_n),
    .valid_i(valid_i), .ready_o(r0),
    .ctrl_i(ctrl_i), .data_i(data_i),
    .flush_i(flush_i),
    .valid_o(v0), .ready_i(ready_i),
    .ctrl_o(c0), .data_o(d0), .occ_o(o0)
  );

  // Reference model: a FIFO of beats per instance, capacity 2 / 1.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q1[$];
  beat_t         q0[$];
  logic [DW-1:0] last1, last0;

  initial begin
    bit a, e;
    q1 = {};
    q0 = {};
    last1 = '0;
    last0 = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q1 = {};
        q0 = {};
        last1 = '0;
        last0 = '0;
      end else begin
        a = valid_i && (q1.size() < 2) && !flush_i;
        e = (q1.size() > 0) && ready_i;
        if (flush_i) q1 = {};
        else begin
          if (e) void'(q1.pop_front());
          if (a) q1.push_back(beat_t'({ctrl_i, data_i}));
        end
        if (q1.size() > 0) last1 = q1[0].d;
        a = valid_i && (q0.size() == 0 || ready_i) && !flush_i;
        e = (q0.size() > 0) && ready_i;
        if (flush_i) q0 = {};
        else begin
          if (e) void'(q0.pop_front());
          if (a) q0.push_back(beat_t'({ctrl_i, data_i}));
        end
        if (q0.size() > 0) last0 = q0[0].d;
      end
    end
  end

  function automatic logic [GW-1:0] got1();
    return {v1, r1, o1, c1, d1};
  endfunction

  function automatic logic [GW-1:0] got0();
    return {v0, r0, o0, c0, d0};
  endfunction

  function automatic logic [GW-1:0] mk(
    input logic v, input logic r, input logic [1:0] o,
    input logic [CW-1:0] c, input logic [DW-1:0] d);
    return {v, r, o, c, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    ctrl_i  = '0;
    data_i  = '0;
  endtask

  task automatic test_reset();
    logic [GW-1:0] exp;
    exp = mk(1'b0, 1'b1, 2'd0, '0, '0);
    rst_n   = 1'b0;
    valid_i = 1'b1;
    ctrl_i  = 4'hF;
    data_i  = DW'(8'hA5);
    ready_i = 1'b1;
    flush_i = 1'b0;
    #1;
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL reset_during_s1 got %h exp %h", got1(), exp);
    end
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL reset_during_s0 got %h exp %h", got0(), exp);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL reset_held_s1 got %h exp %h", got1(), exp);
    end
    cyc();
    rst_n   = 1'b1;
    valid_i = 1'b0;
    #1;
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL reset_after_s1 got %h exp %h", got1(), exp);
    end
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL reset_after_s0 got %h exp %h", got0(), exp);
    end
  endtask

  task automatic test_stream();
    logic [GW-1:0] exp;
    for (int i = 0; i <= 8; i++) begin
      cyc();
      idle();
      valid_i = (i < 8);
      ctrl_i  = 4'hF;
      data_i  = DW'(i);
      @(negedge clk);
      if (i > 0) begin
        exp = mk(1'b1, 1'b1, 2'd1, 4'hF, DW'(i - 1));
        checks++;
        if (got1() !== exp) begin
          errors++;
          $display("FAIL stream_%0d got %h exp %h", i, got1(), exp);
        end
      end
    end
    cyc();
    idle();
    @(negedge clk);
    exp = mk(1'b0, 1'b1, 2'd0, '0, DW'(7));
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL stream_drain got %h exp %h", got1(), exp);
    end
  endtask

  task automatic test_stall();
    logic [GW-1:0] exp [6];
    logic [7:0]    din [6];
    logic          rin [6];
    logic          vin [6];
    din = '{8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h00};
    rin = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp[0] = mk(1'b0, 1'b1, 2'd0, '0, DW'(7));
    exp[1] = mk(1'b1, 1'b1, 2'd1, 4'hF, DW'(8'h10));
    exp[2] = mk(1'b1, 1'b0, 2'd2, 4'hF, DW'(8'h10));
    exp[3] = mk(1'b1, 1'b0, 2'd2, 4'hF, DW'(8'h10));
    exp[4] = mk(1'b1, 1'b1, 2'd1, 4'hF, DW'(8'h11));
    exp[5] = mk(1'b1, 1'b1, 2'd1, 4'hF, DW'(8'h12));
    for (int i = 0; i < 6; i++) begin
      cyc();
      idle();
      valid_i = vin[i];
      ready_i = rin[i];
      ctrl_i  = 4'hF;
      data_i  = DW'(din[i]);
      @(negedge clk);
      checks++;
      if (got1() !== exp[i]) begin
        errors++;
        $display("FAIL stall_%0d got %h exp %h", i, got1(), exp[i]);
      end
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if (got1() !== mk(1'b0, 1'b1, 2'd0, '0, DW'(8'h12))) begin
      errors++;
      $display("FAIL stall_drain got %h", got1());
    end
  endtask

  task automatic test_flush_full();
    logic [GW-1:0] exp;
    cyc();
    idle();
    valid_i = 1'b1;
    ready_i = 1'b0;
    ctrl_i  = 4'hF;
    data_i  = DW'(8'h20);
    cyc();
    data_i  = DW'(8'h21);
    cyc();
    data_i  = DW'(8'h99);
    flush_i = 1'b1;
    @(negedge clk);
    exp = mk(1'b1, 1'b0, 2'd2, 4'hF, DW'(8'h20));
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL flush_pre got %h exp %h", got1(), exp);
    end
    cyc();
    idle();
    exp = mk(1'b0, 1'b1, 2'd0, '0, DW'(8'h20));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (got1() !== exp) begin
        errors++;
        $display("FAIL flush_post_%0d got %h exp %h", i, got1(), exp);
      end
      cyc();
    end
  endtask

  task automatic test_bubble();
    logic [GW-1:0] exp;
    cyc();
    idle();
    valid_i = 1'b1;
    ctrl_i  = 4'b0011;
    data_i  = DW'(8'h55);
    cyc();
    idle();
    ctrl_i = 4'hF;
    @(negedge clk);
    exp = mk(1'b1, 1'b1, 2'd1, 4'b0011, DW'(8'h55));
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL bubble_hold got %h exp %h", got1(), exp);
    end
    cyc();
    @(negedge clk);
    exp = mk(1'b0, 1'b1, 2'd0, '0, DW'(8'h55));
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL bubble_mask got %h exp %h", got1(), exp);
    end
  endtask

  task automatic test_skid0_stall();
    logic [GW-1:0] exp;
    cyc();
    idle();
    valid_i = 1'b1;
    ctrl_i  = 4'h5;
    data_i  = DW'(8'h30);
    cyc();
    ready_i = 1'b0;
    ctrl_i  = 4'h6;
    data_i  = DW'(8'h31);
    @(negedge clk);
    exp = mk(1'b1, 1'b0, 2'd1, 4'h5, DW'(8'h30));
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL s0_stall got %h exp %h", got0(), exp);
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL s0_ready_comb got %b exp 1", r0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    exp = mk(1'b1, 1'b1, 2'd1, 4'h6, DW'(8'h31));
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL s0_replace got %h exp %h", got0(), exp);
    end
    cyc();
    @(negedge clk);
    exp = mk(1'b0, 1'b1, 2'd0, '0, DW'(8'h31));
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL s0_drain got %h exp %h", got0(), exp);
    end
  endtask

  task automatic test_reset_midflight();
    logic [GW-1:0] exp;
    cyc();
    idle();
    valid_i = 1'b1;
    ready_i = 1'b0;
    data_i  = DW'(8'h40);
    ctrl_i  = 4'h9;
    cyc();
    data_i = DW'(8'h41);
    cyc();
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp = mk(1'b0, 1'b1, 2'd0, '0, '0);
    checks++;
    if (got1() !== exp) begin
      errors++;
      $display("FAIL midrst_s1 got %h exp %h", got1(), exp);
    end
    checks++;
    if (got0() !== exp) begin
      errors++;
      $display("FAIL midrst_s0 got %h exp %h", got0(), exp);
    end
    cyc();
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_random();
    logic [95:0]   r;
    logic [GW-1:0] e1, e0;
    logic [CW-1:0] hc;
    for (int i = 0; i < 600; i++) begin
      cyc();
      r = {$urandom, $urandom, $urandom};
      valid_i = ($urandom_range(3, 0) != 0);
      flush_i = ($urandom_range(15, 0) == 0);
      ctrl_i  = CW'($urandom);
      data_i  = r[DW-1:0];
      if ((i % 64) < 32) ready_i = 1'($urandom_range(1, 0));
      else ready_i = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      hc = (q1.size() > 0) ? q1[0].c : '0;
      e1 = mk(q1.size() > 0, q1.size() < 2,
              2'(q1.size()), hc, last1);
      hc = (q0.size() > 0) ? q0[0].c : '0;
      e0 = mk(q0.size() > 0, (q0.size() == 0) || ready_i,
              2'(q0.size()), hc, last0);
      checks++;
      if (got1() !== e1) begin
        errors++;
        $display("FAIL rand_s1_%0d got %h exp %h", i, got1(), e1);
      end
      checks++;
      if (got0() !== e0) begin
        errors++;
        $display("FAIL rand_s0_%0d got %h exp %h", i, got0(), e0);
      end
    end
    cyc();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_bubble();
    test_skid0_stall();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
